vidpix_reader: RTL

- Read-side counterpart of the mouse-draw pixel writer.
- Accepts a span request (x, y, length) and reads the packed video SRAM, 4 pixels per 16-bit word. Reads happen only in the bus window granted by the VGA controller, outside Gate.
- Unpacks the 3-bit pixel colours and streams them out through a valid/ready port.
- Serves colour-picker and line-readback/screen-dump clients sitting beside the draw FSM in the top level.

---
 rtl/vidpix_pkg.sv | 33 +++
 rtl/vidpix_reader_if.sv | 24 ++
 rtl/vidpix_unpack.sv | 22 ++
 rtl/vidpix_reader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vidpix_pkg.sv
// Shared constants, FSM encoding, SRAM address function and nibble layout for
// the video SRAM pixel reader (shared with the draw FSM).
package vidpix_pkg;

    localparam int unsigned RES_HOR            = 640;
    localparam int unsigned RES_VER            = 480;
    localparam int unsigned WORDS_PER_LINE     = 160;
    localparam int unsigned PIX_PER_WORD       = 4;
    localparam int unsigned VIDRAM_UPPER_LIMIT = 76800;

    localparam int unsigned COLOR_W   = 3;
    localparam int unsigned SPARE_BIT = 3;

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        WAIT_BUS  = 5'b00010,
        SET_ADDR  = 5'b00100,
        READ_WORD = 5'b01000,
        EMIT      = 5'b10000
    } state_e;

    // y*160 built from shifts so it maps onto adders only.
    function automatic logic [17:0] vidpix_addr(input logic [9:0] x, input logic [9:0] y);
        logic [17:0] y18;
        y18 = {8'b0, y};
        return (y18 << 7) + (y18 << 5) + {10'b0, x[9:2]};
    endfunction

    function automatic logic [3:0] nibble_lsb(input logic [1:0] pos);
        return {pos, 2'b00};
    endfunction

endpackage

// File: rtl/vidpix_reader_if.sv
// Span request and pixel stream handshakes of the video SRAM pixel reader.
interface vidpix_reader_if;

    logic       req_valid;
    logic       req_ready;
    logic [9:0] req_x;
    logic [9:0] req_y;
    logic [9:0] req_len;
    logic       pix_valid;
    logic       pix_ready;
    logic [2:0] pix_color;
    logic       pix_last;

    modport master (
        output req_valid, req_x, req_y, req_len, pix_ready,
        input  req_ready, pix_valid, pix_color, pix_last
    );

    modport slave (
        input  req_valid, req_x, req_y, req_len, pix_ready,
        output req_ready, pix_valid, pix_color, pix_last
    );

endinterface

// File: rtl/vidpix_unpack.sv
// Combinational extraction of one 3-bit colour (and, with VIDPIX_NIBBLE_CHECK_EN,
// its spare bit) from a packed 16-bit video word.
module vidpix_unpack
    import vidpix_pkg::*;
(
    input  logic [15:0]        word_i,
    input  logic [1:0]         pos_i,
    output logic [COLOR_W-1:0] color_o
`ifdef VIDPIX_NIBBLE_CHECK_EN
    ,
    output logic               spare_o
`endif
);

    always_comb begin
        color_o = word_i[nibble_lsb(pos_i) +: COLOR_W];
`ifdef VIDPIX_NIBBLE_CHECK_EN
        spare_o = word_i[nibble_lsb(pos_i) + 4'(SPARE_BIT)];
`endif
    end

endmodule

// File: rtl/vidpix_reader.sv
// Reads pixel spans from the packed video SRAM inside the VGA bus window and
// streams the colours out. Optional VIDPIX_NIBBLE_CHECK_EN adds o_fmt_err.
module vidpix_reader
    import vidpix_pkg::*;
(
    input  logic           CLK,
    input  logic           RST,
    vidpix_reader_if.slave bus,
    output logic           o_err,
    input  logic           vidram_client_can_write,
    output logic           o_vidram_rd,
    output logic [17:0]    o_vidram_addr,
    input  logic [15:0]    vidram_data_out
`ifdef VIDPIX_NIBBLE_CHECK_EN
    ,
    output logic           o_fmt_err
`endif
);

    state_e      state_q;
    logic        req_ready_q;
    logic        pix_valid_q;
    logic        pix_last_q;
    logic [2:0]  pix_color_q;
    logic        err_q;
    logic        rd_q;
    logic [17:0] rd_addr_q;
    logic [17:0] word_addr_q;
    logic [9:0]  count_q;
    logic [1:0]  pos_q;
    logic [15:0] word_q;

    logic        req_bad;
    logic [9:0]  len_eff;
    logic [9:0]  room;
    logic [9:0]  span_len;
    logic [15:0] unpack_word;
    logic [1:0]  unpack_pos;
    logic [2:0]  unpack_color;

    always_comb begin
        req_bad  = (bus.req_x >= 10'(RES_HOR)) || (bus.req_y >= 10'(RES_VER));
        len_eff  = (bus.req_len == '0) ? 10'd1 : bus.req_len;
        room     = 10'(RES_HOR) - bus.req_x;
        span_len = (len_eff < room) ? len_eff : room;
    end

    // The single unpacker serves the fresh SRAM word on the first pixel and the
    // buffered word (next position) for the following ones.
    always_comb begin
        unpack_word = word_q;
        unpack_pos  = pos_q + 2'd1;
        if (state_q == READ_WORD) begin
            unpack_word = vidram_data_out;
            unpack_pos  = pos_q;
        end
    end

`ifdef VIDPIX_NIBBLE_CHECK_EN
    logic unpack_spare;
    logic spare_q;

    vidpix_unpack u_unpack (
        .word_i  (unpack_word),
        .pos_i   (unpack_pos),
        .color_o (unpack_color),
        .spare_o (unpack_spare)
    );

    assign o_fmt_err = pix_valid_q & bus.pix_ready & spare_q;
`else
    vidpix_unpack u_unpack (
        .word_i  (unpack_word),
        .pos_i   (unpack_pos),
        .color_o (unpack_color)
    );
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            pix_color_q <= '0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            rd_addr_q   <= '0;
            word_addr_q <= '0;
            count_q     <= '0;
            pos_q       <= '0;
            word_q      <= '0;
`ifdef VIDPIX_NIBBLE_CHECK_EN
            spare_q     <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            req_ready_q <= 1'b0;
                            count_q     <= span_len;
                            pos_q       <= bus.req_x[1:0];
                            word_addr_q <= vidpix_addr(bus.req_x, bus.req_y);
                            state_q     <= WAIT_BUS;
                        end
                    end
                end
                WAIT_BUS: begin
                    if (vidram_client_can_write) begin
                        rd_q      <= 1'b1;
                        rd_addr_q <= word_addr_q;
                        state_q   <= SET_ADDR;
                    end
                end
                SET_ADDR: begin
                    if (!vidram_client_can_write) begin
                        rd_q    <= 1'b0;
                        state_q <= WAIT_BUS;
                    end else begin
                        state_q <= READ_WORD;
                    end
                end
                READ_WORD: begin
                    rd_q <= 1'b0;
                    if (!vidram_client_can_write) begin
                        state_q <= WAIT_BUS;
                    end else begin
                        word_q      <= vidram_data_out;
                        pix_valid_q <= 1'b1;
                        pix_color_q <= unpack_color;
                        pix_last_q  <= (count_q == 10'd1);
`ifdef VIDPIX_NIBBLE_CHECK_EN
                        spare_q     <= unpack_spare;
`endif
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.pix_ready) begin
                        if (count_q == 10'd1) begin
                            pix_valid_q <= 1'b0;
                            pix_last_q  <= 1'b0;
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            count_q <= count_q - 10'd1;
                            pos_q   <= pos_q + 2'd1;
                            if (pos_q == 2'(PIX_PER_WORD - 1)) begin
                                word_addr_q <= word_addr_q + 18'd1;
                                pix_valid_q <= 1'b0;
                                pix_last_q  <= 1'b0;
                                state_q     <= WAIT_BUS;
                            end else begin
                                pix_color_q <= unpack_color;
                                pix_last_q  <= (count_q == 10'd2);
`ifdef VIDPIX_NIBBLE_CHECK_EN
                                spare_q     <= unpack_spare;
`endif
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_color = pix_color_q;
    assign bus.pix_last  = pix_last_q;
    assign o_err         = err_q;
    assign o_vidram_rd   = rd_q;
    assign o_vidram_addr = rd_addr_q;

endmodule
